// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared types and encodings for the multicycle core controller
// Purpose: FSM state type, opcode constants, ALU operation and aluop encodings.
// Ports: none (package).
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath signal bundle
// Purpose: groups instruction fields, status flags and control outputs.
// Ports: master = controller (reads op/funct3/f7b5/zero/mem_ready, drives controls);
//        slave  = datapath (the reverse direction).
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       f7b5;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic       regwrite;
  logic [2:0] alucontrol;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, funct3, f7b5, zero, mem_ready,
    output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           immsrc, regwrite, alucontrol, instr_done, illegal_op
  );

  modport slave (
    output op, funct3, f7b5, zero, mem_ready,
    input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           immsrc, regwrite, alucontrol, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// rtl/multicycle_controller_aludec.sv - ALU operation decoder
// Purpose: maps aluop plus instruction fields to the ALU operation code.
// Ports: aluop, funct3, op5 (instr[5]), f7b5 (instr[30]) in; alucontrol out.
module aludec
  import core_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       f7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type uses instr[30] as sub; for addi it is immediate data.
          3'b000:  alucontrol = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V main controller FSM
// Purpose: sequences fetch/decode/execute/memory/writeback for lw, sw, R, I-ALU, beq, jal.
// Ports: clk, reset_n (sync, active-low); bus (master modport) carries instruction
//        fields, zero, mem_ready and every datapath select/enable.
module multicycle_controller
  import core_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  multicycle_controller_if.master   bus
);

  state_t state, state_next;

  logic   pcupdate, branch;
  logic   irwrite_raw, memwrite_raw, regwrite_raw, done_raw, illegal_raw;
  aluop_t aluop;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = S_FETCH;
    pcupdate      = 1'b0;
    branch        = 1'b0;
    irwrite_raw   = 1'b0;
    memwrite_raw  = 1'b0;
    regwrite_raw  = 1'b0;
    done_raw      = 1'b0;
    illegal_raw   = 1'b0;
    aluop         = ALUOP_ADD;
    bus.adrsrc    = 1'b0;
    bus.resultsrc = 2'b00;
    bus.alusrca   = 2'b00;
    bus.alusrcb   = 2'b00;
    case (state)
      S_FETCH: begin
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
        irwrite_raw   = bus.mem_ready;
        pcupdate      = bus.mem_ready;
        state_next    = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes OldPC + ImmExt so BEQ can use it as the target.
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next  = S_FETCH;
            illegal_raw = 1'b1;
            done_raw    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        state_next  = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.adrsrc = 1'b1;
        state_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        bus.resultsrc = 2'b01;
        regwrite_raw  = 1'b1;
        done_raw      = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adrsrc   = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = bus.mem_ready;
        state_next   = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        bus.alusrca = 2'b10;
        aluop       = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        aluop       = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_next   = S_FETCH;
      end
      S_BEQ: begin
        bus.alusrca = 2'b10;
        aluop       = ALUOP_SUB;
        branch      = 1'b1;
        done_raw    = 1'b1;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        // PC <= target held in ALUOut from DECODE; ALU forms OldPC + 4 for rd.
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        pcupdate    = 1'b1;
        state_next  = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.immsrc = 2'b00;
    case (bus.op)
      OP_SW:   bus.immsrc = 2'b01;
      OP_BEQ:  bus.immsrc = 2'b10;
      OP_JAL:  bus.immsrc = 2'b11;
      default: bus.immsrc = 2'b00;
    endcase
  end

  // Enables are masked by reset in the same cycle so nothing commits mid-reset.
  assign bus.pcwrite    = reset_n & (pcupdate | (branch & bus.zero));
  assign bus.irwrite    = reset_n & irwrite_raw;
  assign bus.memwrite   = reset_n & memwrite_raw;
  assign bus.regwrite   = reset_n & regwrite_raw;
  assign bus.instr_done = reset_n & done_raw;
  assign bus.illegal_op = reset_n & illegal_raw;

  aludec u_aludec (
    .aluop      (aluop),
    .funct3     (bus.funct3),
    .op5        (bus.op[5]),
    .f7b5       (bus.f7b5),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  import core_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller #(.RESET_STATE(S_FETCH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       nm;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] p_op = OP_LW;
  logic [2:0] p_f3 = 3'b000;
  logic       p_f7 = 1'b0;

  // {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, immsrc,
  //  regwrite, alucontrol, instr_done, illegal_op}
  function automatic logic [17:0] ov(input logic pcw, input logic adr, input logic mw,
      input logic irw, input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
      input logic [1:0] imm, input logic rw, input logic [2:0] alc, input logic dn,
      input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alc, dn, ill};
  endfunction

  function automatic logic [17:0] fetch_v(input logic mr, input logic [1:0] imm);
    return ov(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, imm, 0, ALU_ADD, 0, 0);
  endfunction

  function automatic logic [17:0] decode_v(input logic [1:0] imm);
    return ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, ALU_ADD, 0, 0);
  endfunction

  function automatic logic [17:0] aluwb_v(input logic [1:0] imm);
    return ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 1, ALU_ADD, 1, 0);
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    p_op = o;
    p_f3 = f3;
    p_f7 = f7;
  endtask

  // One clock cycle: apply inputs just after the edge, queue the expected outputs.
  task automatic cyc(input string nm, input logic rn, input logic mr, input logic z,
                     input logic [17:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    reset_n       = rn;
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.op        = p_op;
    bus.funct3    = p_f3;
    bus.f7b5      = p_f7;
    x.nm = nm;
    x.v  = e;
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e = exp_q.pop_front();
      act = {bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite, bus.resultsrc,
             bus.alusrca, bus.alusrcb, bus.immsrc, bus.regwrite, bus.alucontrol,
             bus.instr_done, bus.illegal_op};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s actual=%b required=%b", e.nm, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op = OP_LW; bus.funct3 = 3'b000; bus.f7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b0;

    // Reset: FETCH selects, all enables low even with mem_ready high.
    cyc("reset", 0, 1, 0, fetch_v(0, 2'b00));

    // lw with one fetch stall and one memory stall
    set_instr(OP_LW, 3'b010, 0);
    cyc("lw_fetch_stall", 1, 0, 0, fetch_v(0, 2'b00));
    cyc("lw_fetch",       1, 1, 0, fetch_v(1, 2'b00));
    cyc("lw_decode",      1, 1, 0, decode_v(2'b00));
    cyc("lw_memadr",      1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, ALU_ADD, 0, 0));
    cyc("lw_memread_wait",1, 0, 0, ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, ALU_ADD, 0, 0));
    cyc("lw_memread",     1, 1, 0, ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, ALU_ADD, 0, 0));
    cyc("lw_memwb",       1, 1, 0, ov(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, ALU_ADD, 1, 0));

    // sw with three wait cycles in MEMWRITE
    set_instr(OP_SW, 3'b010, 0);
    cyc("sw_fetch",   1, 1, 0, fetch_v(1, 2'b01));
    cyc("sw_decode",  1, 1, 0, decode_v(2'b01));
    cyc("sw_memadr",  1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, ALU_ADD, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc("sw_memwrite_wait", 1, 0, 0, ov(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, ALU_ADD, 0, 0));
    cyc("sw_memwrite_done", 1, 1, 0, ov(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, ALU_ADD, 1, 0));

    // R-type sub
    set_instr(OP_R, 3'b000, 1);
    cyc("sub_fetch",  1, 1, 0, fetch_v(1, 2'b00));
    cyc("sub_decode", 1, 1, 0, decode_v(2'b00));
    cyc("sub_exec",   1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, ALU_SUB, 0, 0));
    cyc("sub_aluwb",  1, 1, 0, aluwb_v(2'b00));

    // addi with instr[30] set must still add
    set_instr(OP_I, 3'b000, 1);
    cyc("addi_fetch",  1, 1, 0, fetch_v(1, 2'b00));
    cyc("addi_decode", 1, 1, 0, decode_v(2'b00));
    cyc("addi_exec",   1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, ALU_ADD, 0, 0));
    cyc("addi_aluwb",  1, 1, 0, aluwb_v(2'b00));

    // R-type and / I-type slti / R-type or
    set_instr(OP_R, 3'b111, 0);
    cyc("and_fetch",  1, 1, 0, fetch_v(1, 2'b00));
    cyc("and_decode", 1, 1, 0, decode_v(2'b00));
    cyc("and_exec",   1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, ALU_AND, 0, 0));
    cyc("and_aluwb",  1, 1, 0, aluwb_v(2'b00));
    set_instr(OP_I, 3'b010, 0);
    cyc("slti_fetch",  1, 1, 0, fetch_v(1, 2'b00));
    cyc("slti_decode", 1, 1, 0, decode_v(2'b00));
    cyc("slti_exec",   1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, ALU_SLT, 0, 0));
    cyc("slti_aluwb",  1, 1, 0, aluwb_v(2'b00));
    set_instr(OP_R, 3'b110, 0);
    cyc("or_fetch",  1, 1, 0, fetch_v(1, 2'b00));
    cyc("or_decode", 1, 1, 0, decode_v(2'b00));
    cyc("or_exec",   1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, ALU_OR, 0, 0));
    cyc("or_aluwb",  1, 1, 0, aluwb_v(2'b00));

    // beq taken, then not taken; zero is ignored outside BEQ
    set_instr(OP_BEQ, 3'b000, 0);
    cyc("beqt_fetch",  1, 1, 1, fetch_v(1, 2'b10));
    cyc("beqt_decode", 1, 1, 1, decode_v(2'b10));
    cyc("beqt_beq",    1, 1, 1, ov(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, ALU_SUB, 1, 0));
    cyc("beqn_fetch",  1, 1, 0, fetch_v(1, 2'b10));
    cyc("beqn_decode", 1, 1, 0, decode_v(2'b10));
    cyc("beqn_beq",    1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, ALU_SUB, 1, 0));

    // jal
    set_instr(OP_JAL, 3'b000, 0);
    cyc("jal_fetch",  1, 1, 0, fetch_v(1, 2'b11));
    cyc("jal_decode", 1, 1, 0, decode_v(2'b11));
    cyc("jal_jal",    1, 1, 0, ov(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, ALU_ADD, 0, 0));
    cyc("jal_aluwb",  1, 1, 0, aluwb_v(2'b11));

    // illegal opcode
    set_instr(7'b1111111, 3'b000, 0);
    cyc("ill_fetch",  1, 1, 0, fetch_v(1, 2'b00));
    cyc("ill_decode", 1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, ALU_ADD, 1, 1));
    cyc("ill_refetch",1, 0, 0, fetch_v(0, 2'b00));

    // reset during MEMWB of a lw: no writeback, FETCH next
    set_instr(OP_LW, 3'b010, 0);
    cyc("rlw_fetch",   1, 1, 0, fetch_v(1, 2'b00));
    cyc("rlw_decode",  1, 1, 0, decode_v(2'b00));
    cyc("rlw_memadr",  1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, ALU_ADD, 0, 0));
    cyc("rlw_memread", 1, 1, 0, ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, ALU_ADD, 0, 0));
    cyc("rlw_memwb_rst", 0, 1, 0, ov(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, ALU_ADD, 0, 0));
    cyc("rlw_after",   1, 0, 0, fetch_v(0, 2'b00));

    // reset during MEMWRITE of a sw: memwrite drops immediately
    set_instr(OP_SW, 3'b010, 0);
    cyc("rsw_fetch",   1, 1, 0, fetch_v(1, 2'b01));
    cyc("rsw_decode",  1, 1, 0, decode_v(2'b01));
    cyc("rsw_memadr",  1, 1, 0, ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, ALU_ADD, 0, 0));
    cyc("rsw_memwrite_rst", 0, 0, 0, ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, ALU_ADD, 0, 0));
    cyc("rsw_after",   1, 1, 0, fetch_v(1, 2'b01));

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
